// File: rtl/demux1_4_reg.sv
// -----------------------------------------------------------------------------
// demux1_4_reg
//
// Registered 1-to-4 demultiplexer. A single producer offers one WIDTH-bit word
// per cycle on D under an IN_VALID / IN_READY handshake. An accepted word is
// written into one of four holding registers selected by {S1,S0}, or into all
// four when BCAST is set. Each slot presents its word to its own consumer with
// a Vk / Rk handshake. XFER_CNT counts accepted words (broadcast counts once).
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   D                 input data word
//   S0, S1            slot select, slot index = {S1,S0}
//   BCAST             write all four slots; S1:S0 ignored
//   IN_VALID          producer has a word on D
//   IN_READY          word on D is accepted at the next rising edge
//   O0..O3            slot holding registers
//   V0..V3            slot holds an undelivered word
//   R0..R3            consumer takes the slot word at the next rising edge
//   XFER_CNT          accepted-word counter, wraps modulo 2^16
// -----------------------------------------------------------------------------
module demux1_4_reg #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] D,
  input  logic             S0,
  input  logic             S1,
  input  logic             BCAST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic             V0,
  output logic             V1,
  output logic             V2,
  output logic             V3,
  input  logic             R0,
  input  logic             R1,
  input  logic             R2,
  input  logic             R3,
  output logic [15:0]      XFER_CNT
);

  // Gather the per-slot scalar ports into vectors so each slot is handled by
  // the same loop body.
  logic [3:0] slot_rdy;
  logic [1:0] sel;

  assign slot_rdy = {R3, R2, R1, R0};
  assign sel      = {S1, S0};

  // State: per-slot valid bit and data word, plus the transfer counter.
  logic [3:0]            valid_q, valid_d;
  logic [3:0][WIDTH-1:0] data_q,  data_d;
  logic [15:0]           xfer_cnt_q, xfer_cnt_d;

  // Handshake decode.
  logic [3:0] slot_free;
  logic       in_ready;
  logic       accept;
  logic [3:0] write_en;

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first so no path through the block leaves it unassigned (no latch).
    write_en = '0;

    // A slot can take a new word if it is empty or is being drained this
    // cycle; that lets a consumer holding Rk=1 sustain one word per cycle.
    slot_free = ~valid_q | slot_rdy;

    // Broadcast must not overwrite any held word, so it waits for all four.
    in_ready  = BCAST ? (&slot_free) : slot_free[sel];
    accept    = IN_VALID & in_ready;

    if (accept) begin
      write_en = BCAST ? 4'b1111 : (4'b0001 << sel);
    end
  end

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    xfer_cnt_d = xfer_cnt_q + {15'd0, accept};

    for (int k = 0; k < 4; k++) begin
      if (write_en[k]) begin
        // A refill takes priority over a delivery in the same cycle: the
        // slot stays valid and carries the new word.
        valid_d[k] = 1'b1;
        data_d[k]  = D;
      end else if (valid_q[k] && slot_rdy[k]) begin
        // Delivered: drop the valid bit, keep the last word on the output.
        valid_d[k] = 1'b0;
      end
    end
  end

  // NOTE: the data registers are reset along with the valid bits because the
  // slot outputs are defined to read zero after reset, not just be invalid.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q    <= '0;
      data_q     <= '0;
      xfer_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed before this edge, independent of statement order.
      valid_q    <= valid_d;
      data_q     <= data_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign IN_READY = in_ready;

  assign O0 = data_q[0];
  assign O1 = data_q[1];
  assign O2 = data_q[2];
  assign O3 = data_q[3];

  assign V0 = valid_q[0];
  assign V1 = valid_q[1];
  assign V2 = valid_q[2];
  assign V3 = valid_q[3];

  assign XFER_CNT = xfer_cnt_q;

endmodule

// File: tb/tb_demux1_4_reg.sv
// -----------------------------------------------------------------------------
// tb_demux1_4_reg
//
// Self-checking bench for demux1_4_reg. A behavioural model holds the four
// slot words, their pending flags and an integer transfer count, and is
// advanced once per clock from the same inputs driven to the DUT. Inputs are
// changed just after the rising edge; IN_READY is compared mid-cycle and the
// registered outputs one time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_demux1_4_reg;

  logic        CLK;
  logic        RST_N;
  logic [15:0] D;
  logic        S0, S1, BCAST, IN_VALID;
  logic        IN_READY;
  logic [15:0] O0, O1, O2, O3;
  logic        V0, V1, V2, V3;
  logic        R0, R1, R2, R3;
  logic [15:0] XFER_CNT;

  // Driver-side variables.
  logic [1:0] sel_i;
  logic [3:0] r_i;

  assign S0 = sel_i[0];
  assign S1 = sel_i[1];
  assign R0 = r_i[0];
  assign R1 = r_i[1];
  assign R2 = r_i[2];
  assign R3 = r_i[3];

  demux1_4_reg #(.WIDTH(16)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .D        (D),
    .S0       (S0),
    .S1       (S1),
    .BCAST    (BCAST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .O0       (O0),
    .O1       (O1),
    .O2       (O2),
    .O3       (O3),
    .V0       (V0),
    .V1       (V1),
    .V2       (V2),
    .V3       (V3),
    .R0       (R0),
    .R1       (R1),
    .R2       (R2),
    .R3       (R3),
    .XFER_CNT (XFER_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observed outputs as arrays for per-slot comparison.
  logic [15:0] obs_o [4];
  logic        obs_v [4];
  assign obs_o[0] = O0;
  assign obs_o[1] = O1;
  assign obs_o[2] = O2;
  assign obs_o[3] = O3;
  assign obs_v[0] = V0;
  assign obs_v[1] = V1;
  assign obs_v[2] = V2;
  assign obs_v[3] = V3;

  // Reference model.
  logic [15:0] exp_o [4];
  bit          exp_v [4];
  int          exp_cnt;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s O%0d", tag, k), {16'd0, obs_o[k]}, {16'd0, exp_o[k]});
      check($sformatf("%s V%0d", tag, k), {31'd0, obs_v[k]}, {31'd0, exp_v[k]});
    end
    check($sformatf("%s XFER_CNT", tag), {16'd0, XFER_CNT}, exp_cnt);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      exp_o[k] = 16'h0000;
      exp_v[k] = 1'b0;
    end
    exp_cnt = 0;
  endtask

  // Ready from the rules: the target slot (or every slot for broadcast) must
  // be empty or being taken by its consumer right now.
  function automatic bit model_ready();
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (BCAST || int'(sel_i) == k) begin
        if (exp_v[k] && !r_i[k]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  task automatic model_edge(input bit rdy);
    bit written [4];
    for (int k = 0; k < 4; k++) written[k] = 1'b0;
    if (IN_VALID && rdy) begin
      for (int k = 0; k < 4; k++) begin
        if (BCAST || int'(sel_i) == k) begin
          exp_o[k]   = D;
          exp_v[k]   = 1'b1;
          written[k] = 1'b1;
        end
      end
      exp_cnt = (exp_cnt + 1) % 65536;
    end
    for (int k = 0; k < 4; k++) begin
      if (!written[k] && exp_v[k] && r_i[k]) exp_v[k] = 1'b0;
    end
  endtask

  // One clock: check IN_READY mid-cycle, advance the model, then compare the
  // registered outputs just after the edge. Caller sets inputs beforehand.
  task automatic step(input bit chk, input string tag);
    bit rdy_m;
    #1;
    rdy_m = model_ready();
    if (chk) check({tag, " IN_READY"}, {31'd0, IN_READY}, {31'd0, rdy_m});
    model_edge(rdy_m);
    @(posedge CLK);
    #1;
    if (chk) check_all(tag);
  endtask

  task automatic drive(input bit vld, input logic [15:0] data,
                       input logic [1:0] sel, input bit bc, input logic [3:0] r);
    IN_VALID = vld;
    D        = data;
    sel_i    = sel;
    BCAST    = bc;
    r_i      = r;
  endtask

  initial begin
    // Reset with a word presented: it must not be accepted or counted.
    RST_N = 1'b0;
    drive(1'b1, 16'h9999, 2'd0, 1'b0, 4'b0000);
    model_reset();
    #3;
    check_all("reset");
    check("reset IN_READY", {31'd0, IN_READY}, 32'd1);
    @(posedge CLK);
    #1;
    check_all("reset hold");
    RST_N = 1'b1;

    // Steering into each slot with consumers stalled.
    drive(1'b1, 16'h1111, 2'd0, 1'b0, 4'b0000); step(1'b1, "steer0");
    drive(1'b1, 16'h2222, 2'd1, 1'b0, 4'b0000); step(1'b1, "steer1");
    drive(1'b1, 16'h3333, 2'd2, 1'b0, 4'b0000); step(1'b1, "steer2");
    drive(1'b1, 16'h4444, 2'd3, 1'b0, 4'b0000); step(1'b1, "steer3");
    check("steer count", {16'd0, XFER_CNT}, 32'd4);
    drive(1'b1, 16'h5555, 2'd2, 1'b0, 4'b0000); step(1'b1, "steer full");
    check("steer O2 held", {16'd0, O2}, 32'h3333);

    // Drain everything, then backpressure and refill on slot 1.
    drive(1'b0, 16'h0000, 2'd0, 1'b0, 4'b1111); step(1'b1, "drain");
    drive(1'b1, 16'hAAAA, 2'd1, 1'b0, 4'b0000); step(1'b1, "fill1");
    drive(1'b1, 16'hBBBB, 2'd1, 1'b0, 4'b0000); step(1'b1, "bp1");
    check("bp1 O1 held", {16'd0, O1}, 32'hAAAA);
    drive(1'b1, 16'hBBBB, 2'd1, 1'b0, 4'b0010); step(1'b1, "refill1");
    check("refill1 O1", {16'd0, O1}, 32'hBBBB);
    check("refill1 V1", {31'd0, V1}, 32'd1);

    // Broadcast blocked by one full, stalled slot, then released.
    drive(1'b0, 16'h0000, 2'd0, 1'b0, 4'b1111); step(1'b1, "drain2");
    drive(1'b1, 16'h5A5A, 2'd2, 1'b0, 4'b0000); step(1'b1, "fill2");
    drive(1'b1, 16'hCAFE, 2'd0, 1'b1, 4'b0000); step(1'b1, "bcast blocked");
    check("bcast blocked ready", {31'd0, IN_READY}, 32'd0);
    drive(1'b1, 16'hCAFE, 2'd0, 1'b1, 4'b0100); step(1'b1, "bcast");
    for (int k = 0; k < 4; k++)
      check($sformatf("bcast slot%0d", k), {16'd0, obs_o[k]}, 32'hCAFE);

    // Streaming into slot 3 with its consumer always ready.
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 16'(i), 2'd3, 1'b0, 4'b1000);
      step(1'b1, "stream");
    end
    check("stream final O3", {16'd0, O3}, 32'h0063);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), 4'($urandom));
      step(1'b1, "random");
    end

    // Fill all slots, then reset asynchronously mid-cycle.
    drive(1'b1, 16'hF00D, 2'd0, 1'b1, 4'b1111); step(1'b1, "prefill");
    drive(1'b0, 16'h0000, 2'd0, 1'b0, 4'b0000); step(1'b1, "prefill hold");
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_all("async reset");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Counter wrap: 65535 accepts reach 0xFFFF, one more wraps to zero.
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 16'(i), 2'd3, 1'b0, 4'b1000);
      step(1'b0, "preload");
    end
    check_all("preload");
    check("preload count", {16'd0, XFER_CNT}, 32'hFFFF);
    drive(1'b1, 16'h1234, 2'd3, 1'b0, 4'b1000); step(1'b1, "wrap");
    check("wrap count", {16'd0, XFER_CNT}, 32'h0000);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
